// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared types and constants for the pulse sequencer.
package pulse_seq_pkg;
    localparam int NUM_CH = 6;
    localparam int TIME_W = 16;
    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic              en;
        logic [TIME_W-1:0] dly;
        logic [TIME_W-1:0] wid;
    } ch_cfg_t;
endpackage

// File: rtl/pulse_seq_channel.sv
// pulse_seq_channel: registered trigger bit, high while pos lies in [dly, dly+wid).
module pulse_seq_channel
    import pulse_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ch_cfg_t           i_cfg,
    input  logic [TIME_W-1:0] i_pos,
    input  logic              i_clr,
    output logic              o_trig
);
    logic [TIME_W:0] w_end;
    logic            w_hit;
    assign w_end = {1'b0, i_cfg.dly} + {1'b0, i_cfg.wid};
    assign w_hit = i_cfg.en && (i_pos >= i_cfg.dly) && ({1'b0, i_pos} < w_end);
    always_ff @(posedge clk) begin
        if (rst || i_clr) o_trig <= 1'b0;
        else              o_trig <= w_hit;
    end
endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: frame scheduler producing one delayed pulse per enabled channel per frame.
// Define PULSE_SEQ_EXT_TRIG_EN to let a synchronized rising edge of ext_trig launch a frame.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int TICK_DIV = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ext_trig,
    input  logic [NUM_CH-1:0] enable_trigger,
    input  logic              multi_pulse,
    input  logic [TIME_W-1:0] frequency,
    input  logic [TIME_W-1:0] pulse_width_0,
    input  logic [TIME_W-1:0] pulse_width_1,
    input  logic [TIME_W-1:0] pulse_width_2,
    input  logic [TIME_W-1:0] pulse_width_3,
    input  logic [TIME_W-1:0] pulse_width_4,
    input  logic [TIME_W-1:0] pulse_width_5,
    input  logic [TIME_W-1:0] pulse_delay_0,
    input  logic [TIME_W-1:0] pulse_delay_1,
    input  logic [TIME_W-1:0] pulse_delay_2,
    input  logic [TIME_W-1:0] pulse_delay_3,
    input  logic [TIME_W-1:0] pulse_delay_4,
    input  logic [TIME_W-1:0] pulse_delay_5,
    output logic [NUM_CH-1:0] trig_out,
    output logic              busy,
    output logic              frame_done,
    output logic [TIME_W-1:0] frame_cnt
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t            r_state;
    logic [PW-1:0]     r_presc;
    logic [TIME_W-1:0] r_pos;
    logic [TIME_W-1:0] r_per;
    ch_cfg_t           r_cfg [NUM_CH];
    ch_cfg_t           w_cfg [NUM_CH];
    logic              w_wrap;
    logic              w_frame_end;
    logic              w_start;
    logic              w_load;
    logic              w_clr;

    always_comb begin
        w_cfg[0] = '{enable_trigger[0], pulse_delay_0, pulse_width_0};
        w_cfg[1] = '{enable_trigger[1], pulse_delay_1, pulse_width_1};
        w_cfg[2] = '{enable_trigger[2], pulse_delay_2, pulse_width_2};
        w_cfg[3] = '{enable_trigger[3], pulse_delay_3, pulse_width_3};
        w_cfg[4] = '{enable_trigger[4], pulse_delay_4, pulse_width_4};
        w_cfg[5] = '{enable_trigger[5], pulse_delay_5, pulse_width_5};
    end

`ifdef PULSE_SEQ_EXT_TRIG_EN
    logic [2:0] r_sync;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[1:0], ext_trig};
    end
    assign w_start = start | (r_sync[1] & ~r_sync[2]);
`else
    logic w_unused_ext;
    assign w_unused_ext = ext_trig;
    assign w_start      = start;
`endif

    assign w_wrap      = (r_presc == PW'(TICK_DIV - 1));
    assign w_frame_end = (r_state == RUN) && w_wrap && (r_pos == r_per - TIME_W'(1));
    assign w_load      = !abort && ((r_state == IDLE) ? w_start : (w_frame_end && multi_pulse));
    assign w_clr       = abort || (r_state != RUN) || w_frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_pos      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                busy    <= 1'b0;
            end else if (r_state == RUN) begin
                r_presc <= w_wrap ? '0 : r_presc + PW'(1);
                if (w_frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + TIME_W'(1);
                    r_pos      <= '0;
                    r_state    <= multi_pulse ? RUN : IDLE;
                    busy       <= multi_pulse;
                end else if (w_wrap) begin
                    r_pos <= r_pos + TIME_W'(1);
                end
            end else if (w_start) begin
                r_state <= RUN;
                busy    <= 1'b1;
                r_presc <= '0;
                r_pos   <= '0;
            end
        end
    end

    // Shadows snapshot the live config only at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= '{default: '0};
            r_per <= '0;
        end else if (w_load) begin
            r_cfg <= w_cfg;
            r_per <= (frequency == '0) ? TIME_W'(1) : frequency;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pulse_seq_channel u_ch (
            .clk   (clk),
            .rst   (rst),
            .i_cfg (r_cfg[c]),
            .i_pos (r_pos),
            .i_clr (w_clr),
            .o_trig(trig_out[c])
        );
    end
endmodule
